// File: rtl/spram_mport_arb.sv
// NPORTS-port arbitrated front end over 16Kx16 single-port RAM macros (SB_SPRAM256KA pinout).
// Optional round-robin arbitration via `define SPRAM_ARB_RR_EN; default is fixed priority.

// Behavioural stand-in for one SB_SPRAM256KA: nibble-masked write, registered read.
module spram_mport_arb_spram (
    input  logic        clk,
    input  logic [13:0] address,
    input  logic [15:0] datain,
    input  logic [3:0]  maskwren,
    input  logic        wren,
    input  logic        chipselect,
    input  logic        standby,
    input  logic        sleep,
    input  logic        poweroff,
    output logic [15:0] dataout
);
    logic [15:0] mem_r [16384];
    logic        active_s;

    assign active_s = chipselect & ~standby & ~sleep & poweroff;

    // Array access: MASKWREN bit i enables nibble i; contents are never cleared by reset
    always_ff @(posedge clk) begin
        if (active_s) begin
            if (wren) begin
                for (int i = 0; i < 4; i++) begin
                    if (maskwren[i]) begin
                        mem_r[address][4*i +: 4] <= datain[4*i +: 4];
                    end
                end
            end else begin
                dataout <= mem_r[address];
            end
        end
    end
endmodule

module spram_mport_arb #(
    parameter int NPORTS = 2,
    parameter int BANKS  = 1,
    parameter int AW     = 14 + $clog2(BANKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    req,
    input  logic [4*NPORTS-1:0]  wren,
    input  logic [AW*NPORTS-1:0] adr,
    input  logic [32*NPORTS-1:0] di,
    output logic [NPORTS-1:0]    gnt,
    output logic [NPORTS-1:0]    rvalid,
    output logic [32*NPORTS-1:0] rdata
);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic [PW-1:0]    win_s;
    logic             any_s;
    logic [AW-1:0]    sel_adr_s;
    logic [3:0]       sel_wren_s;
    logic [31:0]      sel_di_s;
    logic [BW-1:0]    bank_s;
    logic [BANKS-1:0] cs_s;
    logic             wr_s;
    logic             rd_s;
    logic [31:0]      dout_s [BANKS];
    logic [NPORTS-1:0] rvalid_r;
    logic [BW-1:0]    bank_q_r;

    // Reset gates every grant, which in turn keeps all chip selects low
    assign any_s = (|req) & ~rst;

`ifdef SPRAM_ARB_RR_EN
    logic [PW-1:0] rr_ptr_r;
    logic [PW-1:0] idx_s;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return (s >= NPORTS) ? PW'(s - NPORTS) : PW'(s);
    endfunction

    // Round-robin pick: scanned backwards so the first requester after rr_ptr wins
    always_comb begin
        win_s = '0;
        idx_s = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            idx_s = wrap_idx(rr_ptr_r, i);
            win_s = req[idx_s] ? idx_s : win_s;
        end
    end

    // Pointer moves to the port after the winner; holds when nothing is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (any_s) begin
            rr_ptr_r <= (win_s == PW'(NPORTS - 1)) ? '0 : win_s + 1'b1;
        end
    end
`else
    // Fixed priority pick: lowest requesting index wins
    always_comb begin
        win_s = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            win_s = req[i] ? PW'(i) : win_s;
        end
    end
`endif

    // One-hot grant decode
    always_comb begin
        gnt = '0;
        if (any_s) begin
            gnt[win_s] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

    assign sel_adr_s  = adr[win_s*AW +: AW];
    assign sel_wren_s = wren[win_s*4 +: 4];
    assign sel_di_s   = di[win_s*32 +: 32];
    assign wr_s       = |sel_wren_s;
    assign rd_s       = any_s & ~wr_s;

    generate
        if (BANKS > 1) begin : g_bank_sel
            assign bank_s = sel_adr_s[AW-1 -: BW];
        end else begin : g_bank_one
            assign bank_s = 1'b0;
        end
    endgenerate

    // Chip select only for the addressed bank of a granted access
    always_comb begin
        cs_s = '0;
        for (int b = 0; b < BANKS; b++) begin
            cs_s[b] = any_s & (bank_s == BW'(b));
        end
    end

    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            spram_mport_arb_spram u_lo (
                .clk(clk), .address(sel_adr_s[13:0]), .datain(sel_di_s[15:0]),
                .maskwren({sel_wren_s[1], sel_wren_s[1], sel_wren_s[0], sel_wren_s[0]}),
                .wren(wr_s), .chipselect(cs_s[b]), .standby(1'b0), .sleep(1'b0),
                .poweroff(1'b1), .dataout(dout_s[b][15:0])
            );
            spram_mport_arb_spram u_hi (
                .clk(clk), .address(sel_adr_s[13:0]), .datain(sel_di_s[31:16]),
                .maskwren({sel_wren_s[3], sel_wren_s[3], sel_wren_s[2], sel_wren_s[2]}),
                .wren(wr_s), .chipselect(cs_s[b]), .standby(1'b0), .sleep(1'b0),
                .poweroff(1'b1), .dataout(dout_s[b][31:16])
            );
        end
    endgenerate

    // Read-return tracking: which port gets data next cycle and from which bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_r <= '0;
            bank_q_r <= '0;
        end else begin
            rvalid_r <= rd_s ? gnt : '0;
            if (rd_s) begin
                bank_q_r <= bank_s;
            end
        end
    end

    assign rvalid = rvalid_r;

    // OR-bus read data: only the port with rvalid sees the macro output
    always_comb begin
        rdata = '0;
        for (int p = 0; p < NPORTS; p++) begin
            rdata[p*32 +: 32] = rvalid_r[p] ? dout_s[bank_q_r] : 32'h0000_0000;
        end
    end
endmodule

// File: tb/tb_spram_mport_arb.sv
// Directed self-checking bench for spram_mport_arb (4 ports, 2 banks).
// Honours SPRAM_ARB_RR_EN for the contention expectations.
module tb_spram_mport_arb;
    localparam int NP = 4;
    localparam int NB = 2;
    localparam int AW = 15;

    logic            clk;
    logic            rst;
    logic [NP-1:0]   req;
    logic [4*NP-1:0] wren;
    logic [AW*NP-1:0] adr;
    logic [32*NP-1:0] di;
    logic [NP-1:0]   gnt;
    logic [NP-1:0]   rvalid;
    logic [32*NP-1:0] rdata;

    int checks = 0;
    int fails  = 0;

    spram_mport_arb #(.NPORTS(NP), .BANKS(NB)) dut (
        .clk(clk), .rst(rst), .req(req), .wren(wren), .adr(adr), .di(di),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input int p, input logic [3:0] w, input logic [AW-1:0] a, input logic [31:0] d);
        req[p]          = 1'b1;
        wren[p*4 +: 4]  = w;
        adr[p*AW +: AW] = a;
        di[p*32 +: 32]  = d;
    endtask

    task automatic idle();
        req  = '0;
        wren = '0;
        adr  = '0;
        di   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL reset_rvalid: got %b expected %b", rvalid, 4'b0000); end
        checks++; if (rdata !== 128'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if (dut.cs_s !== 2'b00) begin fails++; $display("FAIL reset_cs: got %b expected %b", dut.cs_s, 2'b00); end
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk); idle(); drive(1, 4'hF, 15'h0010, 32'hDEAD_BEEF);
        #1;
        checks++; if (gnt !== 4'b0010) begin fails++; $display("FAIL basic_wr_gnt: got %b expected %b", gnt, 4'b0010); end
        @(negedge clk); idle(); drive(1, 4'h0, 15'h0010, 32'h0);
        #1;
        checks++; if (gnt !== 4'b0010) begin fails++; $display("FAIL basic_rd_gnt: got %b expected %b", gnt, 4'b0010); end
        checks++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL basic_wr_no_rvalid: got %b expected %b", rvalid, 4'b0000); end
        @(negedge clk); idle();
        #1;
        checks++; if (rvalid !== 4'b0010) begin fails++; $display("FAIL basic_rvalid: got %b expected %b", rvalid, 4'b0010); end
        checks++; if (rdata[63:32] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL basic_rdata1: got %h expected %h", rdata[63:32], 32'hDEAD_BEEF); end
        checks++; if (rdata[31:0] !== 32'h0) begin fails++; $display("FAIL basic_rdata0: got %h expected %h", rdata[31:0], 32'h0); end
    endtask

    task automatic test_byte_mask();
        @(negedge clk); idle(); drive(2, 4'hF, 15'h0020, 32'h1122_3344);
        @(negedge clk); idle(); drive(2, 4'h5, 15'h0020, 32'hAABB_CCDD);
        // port 0 presents a full write to the same word but never requests
        wren[3:0] = 4'hF; adr[14:0] = 15'h0020; di[31:0] = 32'h0;
        #1;
        checks++; if (gnt !== 4'b0100) begin fails++; $display("FAIL mask_gnt: got %b expected %b", gnt, 4'b0100); end
        @(negedge clk); idle(); drive(2, 4'h0, 15'h0020, 32'h0);
        @(negedge clk); idle();
        #1;
        checks++; if (rvalid !== 4'b0100) begin fails++; $display("FAIL mask_rvalid: got %b expected %b", rvalid, 4'b0100); end
        checks++; if (rdata[95:64] !== 32'h11BB_33DD) begin fails++; $display("FAIL mask_rdata: got %h expected %h", rdata[95:64], 32'h11BB_33DD); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_gnt;
        logic [3:0] prev_gnt;
        int cnt [NP];
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int p = 0; p < NP; p++) drive(p, 4'h0, 15'h0010, 32'h0);
        prev_gnt = 4'b0000;
        for (int c = 0; c <= 8; c++) begin
            if (c == 8) idle();
            #1;
`ifdef SPRAM_ARB_RR_EN
            exp_gnt = 4'b0001 << (c % 4);
`else
            exp_gnt = 4'b0001;
`endif
            if (c == 8) exp_gnt = 4'b0000;
            checks++; if (gnt !== exp_gnt) begin fails++; $display("FAIL cont_gnt c=%0d: got %b expected %b", c, gnt, exp_gnt); end
            checks++; if (rvalid !== prev_gnt) begin fails++; $display("FAIL cont_rvalid c=%0d: got %b expected %b", c, rvalid, prev_gnt); end
            for (int p = 0; p < NP; p++) begin
                if (gnt[p]) cnt[p]++;
                if (prev_gnt[p]) begin
                    checks++;
                    if (rdata[p*32 +: 32] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL cont_rdata c=%0d p=%0d: got %h expected %h", c, p, rdata[p*32 +: 32], 32'hDEAD_BEEF); end
                end
            end
            prev_gnt = exp_gnt;
            @(negedge clk);
        end
        for (int p = 0; p < NP; p++) begin
`ifdef SPRAM_ARB_RR_EN
            checks++; if (cnt[p] != 2) begin fails++; $display("FAIL cont_count p=%0d: got %0d expected 2", p, cnt[p]); end
`else
            checks++; if (cnt[p] != ((p == 0) ? 8 : 0)) begin fails++; $display("FAIL cont_count p=%0d: got %0d expected %0d", p, cnt[p], (p == 0) ? 8 : 0); end
`endif
        end
    endtask

    task automatic test_banks();
        @(negedge clk); idle(); drive(0, 4'hF, 15'h0005, 32'h0000_0001);
        #1;
        checks++; if (dut.cs_s !== 2'b01) begin fails++; $display("FAIL bank_wr0_cs: got %b expected %b", dut.cs_s, 2'b01); end
        @(negedge clk); idle(); drive(0, 4'hF, 15'h4005, 32'h0000_0002);
        #1;
        checks++; if (dut.cs_s !== 2'b10) begin fails++; $display("FAIL bank_wr1_cs: got %b expected %b", dut.cs_s, 2'b10); end
        @(negedge clk); idle(); drive(0, 4'h0, 15'h0005, 32'h0);
        #1;
        checks++; if (dut.cs_s !== 2'b01) begin fails++; $display("FAIL bank_rd0_cs: got %b expected %b", dut.cs_s, 2'b01); end
        @(negedge clk); idle(); drive(2, 4'h0, 15'h4005, 32'h0);
        #1;
        checks++; if (dut.cs_s !== 2'b10) begin fails++; $display("FAIL bank_rd1_cs: got %b expected %b", dut.cs_s, 2'b10); end
        checks++; if (rvalid !== 4'b0001) begin fails++; $display("FAIL bank_rvalid0: got %b expected %b", rvalid, 4'b0001); end
        checks++; if (rdata[31:0] !== 32'h0000_0001) begin fails++; $display("FAIL bank_rdata0: got %h expected %h", rdata[31:0], 32'h1); end
        @(negedge clk); idle();
        #1;
        checks++; if (rvalid !== 4'b0100) begin fails++; $display("FAIL bank_rvalid2: got %b expected %b", rvalid, 4'b0100); end
        checks++; if (rdata[95:64] !== 32'h0000_0002) begin fails++; $display("FAIL bank_rdata2: got %h expected %h", rdata[95:64], 32'h2); end
        checks++; if (dut.cs_s !== 2'b00) begin fails++; $display("FAIL bank_idle_cs: got %b expected %b", dut.cs_s, 2'b00); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk); idle(); drive(3, 4'hF, 15'h0123, 32'hCAFE_F00D);
        @(negedge clk); idle(); drive(3, 4'h0, 15'h0123, 32'h0);
        #1;
        checks++; if (gnt !== 4'b1000) begin fails++; $display("FAIL midrst_gnt: got %b expected %b", gnt, 4'b1000); end
        @(posedge clk);
        #1; rst = 1'b1; idle();
        #1;
        checks++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL midrst_rvalid: got %b expected %b", rvalid, 4'b0000); end
        checks++; if (rdata !== 128'h0) begin fails++; $display("FAIL midrst_rdata: got %h expected 0", rdata); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); drive(3, 4'h0, 15'h0123, 32'h0);
        @(negedge clk); idle();
        #1;
        checks++; if (rvalid !== 4'b1000) begin fails++; $display("FAIL midrst_reread_rvalid: got %b expected %b", rvalid, 4'b1000); end
        checks++; if (rdata[127:96] !== 32'hCAFE_F00D) begin fails++; $display("FAIL midrst_reread_rdata: got %h expected %h", rdata[127:96], 32'hCAFE_F00D); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_byte_mask();
        test_contention();
        test_banks();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
